pe_host_link: RTL and testbench

//  Host-side endpoint of one PE's load/output interface. Buffers one frame of LOAD_NUM

---
 rtl/pe_host_link.sv | 135 +++++++++++++
 tb/tb_pe_host_link.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_host_link.sv
// pe_host_link: buffers one upstream frame, bursts it gap-free into a PE,
// then captures the PE result burst and drains it on a valid/ready stream.
module pe_host_link #(
    parameter int DATA_W   = 32,
    parameter int LOAD_NUM = 16,
    parameter int OUT_NUM  = 4,
    parameter int WAIT_MAX = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              pe_din_v,
    output logic [DATA_W-1:0] pe_din,
    input  logic              pe_dout_v,
    input  logic [DATA_W-1:0] pe_dout,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              timeout_err
);
    localparam int IW  = $clog2(LOAD_NUM + 1);
    localparam int LAW = LOAD_NUM > 1 ? $clog2(LOAD_NUM) : 1;
    localparam int OW  = $clog2(OUT_NUM + 1);
    localparam int OAW = OUT_NUM > 1 ? $clog2(OUT_NUM) : 1;
    localparam int WW  = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {FILL, SEND, WAIT, DRAIN} state_t;

    state_t            r_state;
    logic [IW-1:0]     r_idx;
    logic [OW-1:0]     r_cap;
    logic [OW-1:0]     r_rd;
    logic [WW-1:0]     r_wait;
    logic [DATA_W-1:0] r_in_buf  [LOAD_NUM];
    logic [DATA_W-1:0] r_out_buf [OUT_NUM];
    logic              r_pe_din_v;
    logic [DATA_W-1:0] r_pe_din;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_timeout_err;

    logic              w_s_fire;
    logic              w_m_fire;
    logic [OW-1:0]     w_rd_nxt;
    logic [LAW-1:0]    w_in_a;
    logic [OAW-1:0]    w_cap_a;
    logic [OAW-1:0]    w_rd_a;

    assign s_ready     = !rst && r_state == FILL;
    assign w_s_fire    = s_valid && s_ready;
    assign w_m_fire    = r_m_valid && m_ready;
    assign w_rd_nxt    = r_rd + OW'(1);
    assign w_in_a      = r_idx[LAW-1:0];
    assign w_cap_a     = r_cap[OAW-1:0];
    assign w_rd_a      = w_rd_nxt[OAW-1:0];
    assign pe_din_v    = r_pe_din_v;
    assign pe_din      = r_pe_din;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign timeout_err = r_timeout_err;
    assign busy        = r_state != FILL || r_idx != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FILL;
            r_idx         <= '0;
            r_cap         <= '0;
            r_rd          <= '0;
            r_wait        <= '0;
            r_pe_din_v    <= 1'b0;
            r_pe_din      <= '0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                FILL: if (w_s_fire) begin
                    r_in_buf[w_in_a] <= s_data;
                    // The first beat leaves on the same edge as the last handshake,
                    // so r_idx doubles as the send index starting at 1.
                    if (r_idx == IW'(LOAD_NUM - 1)) begin
                        r_state    <= SEND;
                        r_idx      <= IW'(1);
                        r_pe_din_v <= 1'b1;
                        r_pe_din   <= LOAD_NUM == 1 ? s_data : r_in_buf[0];
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                SEND: if (r_idx == IW'(LOAD_NUM)) begin
                    r_state    <= WAIT;
                    r_idx      <= '0;
                    r_wait     <= '0;
                    r_cap      <= '0;
                    r_pe_din_v <= 1'b0;
                    r_pe_din   <= '0;
                end else begin
                    r_pe_din <= r_in_buf[w_in_a];
                    r_idx    <= r_idx + IW'(1);
                end
                WAIT: begin
                    r_wait <= r_wait + WW'(1);
                    if (pe_dout_v) begin
                        r_out_buf[w_cap_a] <= pe_dout;
                        r_cap              <= r_cap + OW'(1);
                    end
                    if (pe_dout_v && r_cap == OW'(OUT_NUM - 1)) begin
                        r_state   <= DRAIN;
                        r_rd      <= '0;
                        r_m_valid <= 1'b1;
                        r_m_data  <= OUT_NUM == 1 ? pe_dout : r_out_buf[0];
                    end else if (r_wait == WW'(WAIT_MAX - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= FILL;
                    end
                end
                DRAIN: if (w_m_fire) begin
                    if (r_rd == OW'(OUT_NUM - 1)) begin
                        r_state   <= FILL;
                        r_rd      <= '0;
                        r_m_valid <= 1'b0;
                        r_m_data  <= '0;
                    end else begin
                        r_rd     <= w_rd_nxt;
                        r_m_data <= r_out_buf[w_rd_a];
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_host_link.sv
// tb_pe_host_link: frame-level reference checks of the pe_host_link load/result path.
module tb_pe_host_link;
    localparam int LN = 16;
    localparam int ON = 4;
    localparam int WM = 4095;

    typedef struct {
        bit seq;
        bit toggle;
        int n_stray;
        int n_res;
        int stall_at;
        int stall_len;
        int exp_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic        pe_din_v;
    logic [31:0] pe_din;
    logic        pe_dout_v = 1'b0;
    logic [31:0] pe_dout = '0;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready = 1'b1;
    logic        busy;
    logic        timeout_err;

    pe_host_link dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .pe_din_v(pe_din_v), .pe_din(pe_din), .pe_dout_v(pe_dout_v), .pe_dout(pe_dout),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          bursts = 0;
    int          idle_bad = 0;
    bit          prev_v = 0;
    bit          hold_pending = 0;
    logic [31:0] held;
    logic        exp_err = 1'b0;
    logic [31:0] frame[$];
    logic [31:0] q_burst[$];
    logic [31:0] q_m[$];
    vec_t        tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic cyc();
        @(negedge clk);
        if (pe_din_v) begin
            if (!prev_v) q_burst.delete();
            q_burst.push_back(pe_din);
        end else if (pe_din !== '0) begin
            idle_bad++;
        end
        if (prev_v && !pe_din_v) bursts++;
        prev_v = pe_din_v;
        if (hold_pending) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== held) begin
                errors++;
                $display("FAIL m_hold: got v=%b d=%0h expected v=1 d=%0h", m_valid, m_data, held);
            end
        end
        hold_pending = 0;
    endtask

    task automatic new_frame(input bit seq);
        frame.delete();
        for (int i = 0; i < LN; i++) frame.push_back(seq ? 32'(i + 1) : $urandom);
    endtask

    task automatic feed(input bit toggle, input string name);
        int  idx = 0;
        int  n = 0;
        bit  ph = 1;
        while (idx < LN && n < 200) begin
            s_valid = toggle ? ph : 1'b1;
            ph = !ph;
            s_data = frame[idx];
            if (s_valid && s_ready) idx++;
            cyc();
            n++;
        end
        s_valid = 1'b0;
        s_data = '0;
        if (idx < LN) fail({name, "_feed"});
    endtask

    task automatic wait_burst(input int b0, input string name);
        int n = 0;
        while (bursts == b0 && n < 60) begin
            cyc();
            n++;
        end
        if (bursts == b0) fail({name, "_burst_wait"});
        chk({name, "_burst_len"}, q_burst.size(), LN);
        for (int i = 0; i < LN && i < q_burst.size(); i++)
            chk($sformatf("%s_pe%0d", name, i), q_burst[i], frame[i]);
    endtask

    task automatic run_frame(input vec_t v, input string name);
        logic [31:0] res[$];
        logic [31:0] exp_q[$];
        int          stall_left = v.stall_len;
        int          mv = 0;
        int          b0;
        int          stall_eff;
        new_frame(v.seq);
        for (int i = 0; i < v.n_res; i++) res.push_back(v.seq ? 32'(10 + i) : $urandom);
        for (int i = 0; i < v.n_res && i < ON; i++) exp_q.push_back(res[i]);
        stall_eff = v.stall_at < v.exp_cnt ? v.stall_len : 0;
        for (int i = 0; i < v.n_stray; i++) begin
            pe_dout_v = 1'b1;
            pe_dout = $urandom;
            cyc();
        end
        pe_dout_v = 1'b0;
        cyc();
        chk({name, "_stray_busy"}, busy, 0);
        chk({name, "_stray_mv"}, m_valid, 0);
        idle_bad = 0;
        q_m.delete();
        b0 = bursts;
        feed(v.toggle, name);
        wait_burst(b0, name);
        for (int c = 0; c < v.n_res + v.stall_len + 12; c++) begin
            pe_dout_v = c < v.n_res;
            pe_dout = c < v.n_res ? res[c] : '0;
            m_ready = !(m_valid && q_m.size() == v.stall_at && stall_left > 0);
            if (!m_ready) stall_left--;
            if (m_valid && m_ready) q_m.push_back(m_data);
            hold_pending = m_valid && !m_ready;
            held = m_data;
            if (m_valid) mv++;
            cyc();
        end
        pe_dout_v = 1'b0;
        m_ready = 1'b1;
        chk({name, "_m_count"}, q_m.size(), v.exp_cnt);
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_m%0d", name, i), i < q_m.size() ? q_m[i] : 32'hx, exp_q[i]);
        chk({name, "_mv_cycles"}, mv, v.exp_cnt + stall_eff);
        chk({name, "_s_ready_after"}, s_ready, 1);
        chk({name, "_busy_after"}, busy, 0);
        chk({name, "_err"}, timeout_err, exp_err);
        chk({name, "_pe_din_idle"}, idle_bad, 0);
    endtask

    task automatic timeout_frame(input int n_partial, input string name);
        int b0;
        int mv = 0;
        new_frame(0);
        idle_bad = 0;
        b0 = bursts;
        feed(0, name);
        wait_burst(b0, name);
        chk({name, "_err_entry"}, timeout_err, exp_err);
        for (int k = 1; k <= WM; k++) begin
            pe_dout_v = k <= n_partial;
            pe_dout = $urandom;
            if (m_valid) mv++;
            cyc();
            if (k == WM - 1) chk({name, "_err_early"}, timeout_err, exp_err);
        end
        pe_dout_v = 1'b0;
        exp_err = 1'b1;
        chk({name, "_err_at_max"}, timeout_err, 1);
        chk({name, "_fill"}, s_ready, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_no_drain"}, mv, 0);
    endtask

    initial begin
        tbl[0] = '{1, 0, 0, 4, 0, 0, 4};
        tbl[1] = '{0, 1, 0, 4, 0, 0, 4};
        tbl[2] = '{0, 0, 0, 4, 1, 5, 4};
        tbl[3] = '{0, 0, 2, 6, 0, 0, 4};
        tbl[4] = '{0, 1, 1, 5, 3, 2, 4};
        tbl[5] = '{0, 0, 0, 4, 0, 3, 4};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk("rst_pe_din_v", pe_din_v, 0);
        chk("rst_pe_din", pe_din, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        rst = 1'b0;
        cyc();
        chk("rel_s_ready", s_ready, 1);

        for (int t = 0; t < 6; t++) run_frame(tbl[t], $sformatf("tbl%0d", t));

        timeout_frame(0, "tmo");
        run_frame(tbl[0], "after_tmo");
        timeout_frame(2, "tmo_partial");

        new_frame(0);
        feed(0, "abort");
        begin
            int n = 0;
            while (!(pe_din_v && q_burst.size() == 7) && n < 40) begin
                cyc();
                n++;
            end
            if (n >= 40) fail("abort_beat7");
        end
        chk("abort_busy", busy, 1);
        chk("abort_beat7_data", pe_din, frame[6]);
        rst = 1'b1;
        cyc();
        chk("abort_v", pe_din_v, 0);
        chk("abort_din", pe_din, 0);
        chk("abort_s_ready", s_ready, 0);
        chk("abort_err_clr", timeout_err, 0);
        rst = 1'b0;
        exp_err = 1'b0;
        cyc();
        chk("abort_rel_s_ready", s_ready, 1);
        chk("abort_rel_busy", busy, 0);
        run_frame(tbl[1], "after_abort");

        for (int r = 0; r < 8; r++) begin
            vec_t v;
            v.seq = 0;
            v.toggle = ($urandom_range(0, 1) == 1);
            v.n_stray = int'($urandom_range(0, 2));
            v.n_res = int'($urandom_range(4, 7));
            v.stall_at = int'($urandom_range(0, 3));
            v.stall_len = int'($urandom_range(0, 4));
            v.exp_cnt = v.n_res < ON ? v.n_res : ON;
            run_frame(v, $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
